// File: rtl/conv_frame_loader_pkg.sv
// Shared definitions for the convolution frame loader: default geometry,
// derived frame sizes, counter width helper and the loader FSM states.
package conv_frame_loader_pkg;

    localparam int DEF_PIX_W   = 4;
    localparam int DEF_IMG_DIM = 5;
    localparam int DEF_NPIX    = DEF_IMG_DIM * DEF_IMG_DIM;
    localparam int DEF_FRAME_W = DEF_PIX_W * DEF_NPIX;

    // Width of a counter that must index 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_NPIX);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/conv_frame_loader.sv
// Packs a row-major pixel stream into one flat IMG_DIM x IMG_DIM frame.
// One frame is presented on the output while the next one assembles; when
// the output slot is still occupied at frame completion the loader stalls
// the input until the consumer takes the old frame.
// Optional feature: define CONV_LOADER_SOF_EN to add the s_sof port, which
// restarts assembly with the flagged beat as pixel 0.
module conv_frame_loader
    import conv_frame_loader_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int IMG_DIM = DEF_IMG_DIM
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [PIX_W-1:0]                 s_pixel,
`ifdef CONV_LOADER_SOF_EN
    input  logic                             s_sof,
`endif
    output logic [PIX_W*IMG_DIM*IMG_DIM-1:0] frame,
    output logic                             frame_valid,
    input  logic                             frame_ready
);

    localparam int NPIX    = IMG_DIM * IMG_DIM;
    localparam int FRAME_W = PIX_W * NPIX;
    localparam int CNT_W   = cnt_width(NPIX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPIX - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_W-1:0]   r_asm;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_fvalid;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_sof;
    logic                 w_last;
    logic                 w_slot_free;
    logic                 w_load_fill;
    logic                 w_load_stall;
    logic [CNT_W-1:0]     w_idx;
    logic [FRAME_W-1:0]   w_asm_nxt;

`ifdef CONV_LOADER_SOF_EN
    assign w_sof = s_sof;
`else
    assign w_sof = 1'b0;
`endif

    assign w_slot_free = !r_fvalid || frame_ready;

    // FSM outputs and next state: FILL accepts beats, STALL holds a complete
    // frame in the assembly register until the output slot frees up.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_ready  = 1'b1;
                w_accept = s_valid;
                // A start-of-frame beat restarts assembly, so it never completes one.
                w_last   = s_valid && !w_sof && (r_cnt == LAST);
                if (w_last && !w_slot_free)
                    w_state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (frame_ready)
                    w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    assign s_ready      = w_ready;
    assign w_load_fill  = w_last && w_slot_free;
    assign w_load_stall = (r_state == ST_STALL) && frame_ready;

    // Assembly register with the current beat merged in; the completed frame
    // is forwarded from here so pixel 24 lands in the output on its own edge.
    always_comb begin
        w_idx     = w_sof ? '0 : r_cnt;
        w_asm_nxt = r_asm;
        if (w_accept)
            w_asm_nxt[int'(w_idx)*PIX_W +: PIX_W] = s_pixel;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    // Pixel position counter: wraps after the last pixel, restarts on SOF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_sof)
                r_cnt <= CNT_W'(1);
            else if (r_cnt == LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Assembly register; stale nibbles are left in place since every one is
    // rewritten before the frame is next loaded out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_asm <= '0;
        else        r_asm <= w_asm_nxt;
    end

    // Output slot: load a finished frame, else drop valid on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame  <= '0;
            r_fvalid <= 1'b0;
        end else if (w_load_fill) begin
            r_frame  <= w_asm_nxt;
            r_fvalid <= 1'b1;
        end else if (w_load_stall) begin
            r_frame  <= r_asm;
            r_fvalid <= 1'b1;
        end else if (r_fvalid && frame_ready) begin
            r_fvalid <= 1'b0;
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_fvalid;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: a queue-based frame model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_conv_frame_loader;

    localparam int PW = 4;
    localparam int NP = 25;
    localparam int FW = PW * NP;
`ifdef CONV_LOADER_SOF_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_pixel = '0;
    logic          s_sof = 1'b0;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic          frame_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    bit rand_fr = 0;
    int n_acc = 0;

    always #5 clk = ~clk;

    conv_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_pixel     (s_pixel),
`ifdef CONV_LOADER_SOF_EN
        .s_sof       (s_sof),
`endif
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    // ---------------- reference model ----------------
    int            q[$];
    logic [FW-1:0] m_out  = '0;
    logic [FW-1:0] m_pend = '0;
    bit            m_ov   = 0;
    bit            m_pv   = 0;

    function automatic logic [FW-1:0] pack(input int p[$]);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < p.size(); k++)
            f[PW*k +: PW] = PW'(p[k]);
        return f;
    endfunction

    task automatic model_step();
        bit acc, hs, ld;
        logic [FW-1:0] f;
        if (!rst_n) begin
            q.delete();
            m_out = '0; m_pend = '0; m_ov = 0; m_pv = 0;
        end else begin
            acc = s_valid && !m_pv;
            hs  = m_ov && frame_ready;
            ld  = 0;
            if (acc) begin
                n_acc++;
                if (SOF_EN && s_sof) q.delete();
                q.push_back(int'(s_pixel));
                if (q.size() == NP) begin
                    f = pack(q);
                    q.delete();
                    if (!m_ov || frame_ready) begin
                        m_out = f; ld = 1;
                    end else begin
                        m_pend = f; m_pv = 1;
                    end
                end
            end else if (m_pv && frame_ready) begin
                m_out = m_pend; m_pv = 0; ld = 1;
            end
            if (ld)      m_ov = 1;
            else if (hs) m_ov = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chki("s_ready", int'(s_ready), int'(!m_pv));
        chki("frame_valid", int'(frame_valid), int'(m_ov));
        chk("frame", frame, m_out);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_fr) frame_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int pix, input bit sof);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_pixel = PW'(pix);
        s_sof   = sof;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        chki("send_timeout", int'(n >= 200), 0);
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    int            st1[NP] = '{5,3,2,1,4,0,0,1,2,3,0,1,1,2,3,4,1,0,1,2,3,1,0,4,1};
    logic [FW-1:0] exp1    = 100'h1401321014321103210041235;

    initial begin
        int qa[$], qb[$], qc[$], qd[$];
        int fv_cnt, fv_first, fv_second, sr_drop, acc0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chki("rst_s_ready", int'(s_ready), 1);
        chki("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_frame", frame, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        frame_ready = 1'b1;
        tick();

        // Directed frame with known packed value
        for (int k = 0; k < NP; k++) send(st1[k], 0);
        chki("t1_fv_after_last", int'(frame_valid), 1);
        chk("t1_frame", frame, exp1);
        tick();
        chki("t1_fv_drop", int'(frame_valid), 0);

        // Two frames back to back with consumer always ready
        fv_cnt = 0; fv_first = -1; fv_second = -1; sr_drop = 0;
        for (int b = 1; b <= 2 * NP; b++) begin
            if (!s_ready) sr_drop++;
            send(st1[(b - 1) % NP], 0);
            if (frame_valid) begin
                fv_cnt++;
                if (fv_first < 0) fv_first = b; else fv_second = b;
            end
        end
        chki("t2_fv_cycles", fv_cnt, 2);
        chki("t2_fv_first", fv_first, 25);
        chki("t2_fv_second", fv_second, 50);
        chki("t2_sready_drops", sr_drop, 0);
        chk("t2_frame", frame, exp1);
        tick();

        // Consumer blocked across two frames -> stall, then release
        frame_ready = 1'b0;
        for (int k = 0; k < NP; k++) qa.push_back($urandom_range(0, 15));
        for (int k = 0; k < NP; k++) qb.push_back($urandom_range(0, 15));
        for (int k = 0; k < NP; k++) send(qa[k], 0);
        chki("t3_fv_a", int'(frame_valid), 1);
        chk("t3_frame_a", frame, pack(qa));
        for (int k = 0; k < NP; k++) send(qb[k], 0);
        chki("t3_stall", int'(s_ready), 0);
        chk("t3_frame_a_held", frame, pack(qa));
        repeat (3) tick();
        chki("t3_stall_hold", int'(s_ready), 0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chki("t3_fv_b", int'(frame_valid), 1);
        chk("t3_frame_b", frame, pack(qb));
        chki("t3_sready_back", int'(s_ready), 1);
        frame_ready = 1'b1;
        tick();

        // Random gaps and random consumer readiness over three frames
        acc0 = n_acc;
        rand_fr = 1;
        for (int b = 0; b < 3 * NP; b++) begin
            while ($urandom_range(0, 1) == 1) begin
                s_pixel = 4'($urandom_range(0, 15));
                tick();
            end
            send($urandom_range(0, 15), 0);
        end
        rand_fr = 0;
        frame_ready = 1'b1;
        repeat (4) tick();
        chki("t4_beats_accepted", n_acc - acc0, 3 * NP);

        // Reset mid-frame discards the partial frame
        for (int k = 0; k < 12; k++) send($urandom_range(1, 15), 0);
        rst_n = 1'b0;
        #2;
        chki("t5_rst_fv", int'(frame_valid), 0);
        chk("t5_rst_frame", frame, '0);
        chki("t5_rst_sready", int'(s_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NP; k++) qc.push_back($urandom_range(0, 15));
        for (int k = 0; k < NP; k++) send(qc[k], 0);
        chki("t5_fv", int'(frame_valid), 1);
        chk("t5_frame", frame, pack(qc));
        tick();

`ifdef CONV_LOADER_SOF_EN
        // Start-of-frame discards a partial frame
        for (int k = 0; k < 7; k++) send($urandom_range(0, 15), 0);
        for (int k = 0; k < NP; k++) qd.push_back($urandom_range(0, 15));
        for (int k = 0; k < NP; k++) send(qd[k], k == 0);
        chki("t6_fv", int'(frame_valid), 1);
        chk("t6_frame", frame, pack(qd));
        tick();
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
